// File: rtl/nanorv32_trace_buf.sv
// Trace capture FIFO for the nanorv32 trace port: buffers retired-instruction words, counts overflow drops, freezes capture on trap.
// Optional overflow marker words are enabled by defining NANORV32_TRACE_BUF_OVF_MARKER_EN.
module nanorv32_trace_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_valid,
  input  logic [WIDTH-1:0]         trace_data,
  input  logic                     trap,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     stopped,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic             capture;
  logic             pop;
  logic             room;
  logic             push;
  logic             drop;
  logic [WIDTH-1:0] wdata;

  assign capture = trace_valid && !stopped;
  assign pop     = out_valid && out_ready;
  // A full FIFO still has room when the head leaves in the same cycle.
  assign room    = (count != FULL_LEVEL) || pop;

`ifdef NANORV32_TRACE_BUF_OVF_MARKER_EN
  logic [31:0] pend;
  logic [31:0] pend_next;

  // A pending marker takes the slot; a trace word arriving alongside it becomes a fresh drop.
  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    wdata     = trace_data;
    pend_next = pend;
    if ((pend != '0) && room) begin
      push      = 1'b1;
      wdata     = WIDTH'({4'hF, pend});
      drop      = capture;
      pend_next = capture ? 32'd1 : 32'd0;
    end else if (capture) begin
      if (room) begin
        push = 1'b1;
      end else begin
        drop = 1'b1;
        if (pend != '1) pend_next = pend + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= pend_next;
  end
`else
  always_comb begin
    push  = capture && room;
    drop  = capture && !room;
    wdata = trace_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stopped  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (trap) stopped <= 1'b1;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign level     = count;
  assign full      = (count == FULL_LEVEL);
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_nanorv32_trace_buf.sv
// Self-checking bench for nanorv32_trace_buf: directed scenarios plus randomized traffic against a queue-based model.
module tb_nanorv32_trace_buf;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 36;

  logic             clk = 1'b0;
  logic             reset;
  logic             trace_valid;
  logic [WIDTH-1:0] trace_data;
  logic             trap;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [4:0]       level;
  logic             full;
  logic             empty;
  logic             stopped;
  logic [15:0]      drop_cnt;

  int tests = 0;
  int fails = 0;

  nanorv32_trace_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .trace_valid(trace_valid), .trace_data(trace_data),
    .trap(trap), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .full(full), .empty(empty), .stopped(stopped), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is a queue, counters are plain integers.
  logic [WIDTH-1:0] mq[$];
  int unsigned      m_drop;
  bit               m_stop;
  longint unsigned  m_pend;

  function automatic void model_step(input bit tv, input logic [WIDTH-1:0] d, input bit trp,
                                     input bit rdy, input bit rst);
    bit pop, cap, room, marker;
    if (rst) begin
      mq.delete(); m_drop = 0; m_stop = 0; m_pend = 0;
      return;
    end
    pop  = (mq.size() != 0) && rdy;
    cap  = tv && !m_stop;
    room = (mq.size() < DEPTH) || pop;
    if (pop) void'(mq.pop_front());
    marker = 1'b0;
`ifdef NANORV32_TRACE_BUF_OVF_MARKER_EN
    marker = (m_pend != 0) && room;
`endif
    if (marker) begin
      mq.push_back({4'hF, 32'(m_pend)});
      if (cap) begin
        if (m_drop < 65535) m_drop++;
        m_pend = 1;
      end else m_pend = 0;
    end else if (cap) begin
      if (room) mq.push_back(d);
      else begin
        if (m_drop < 65535) m_drop++;
        if (m_pend < 64'hFFFF_FFFF) m_pend++;
      end
    end
    if (trp) m_stop = 1;
  endfunction

  function automatic logic [WIDTH-1:0] m_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  task automatic tick(input bit tv, input logic [WIDTH-1:0] d, input bit trp,
                      input bit rdy, input bit rst);
    trace_valid = tv; trace_data = d; trap = trp; out_ready = rdy; reset = rst;
    @(posedge clk);
    model_step(tv, d, trp, rdy, rst);
    #1;
  endtask

  task automatic test_reset();
    tick(0, '0, 0, 0, 1);
    tick(0, '0, 0, 0, 1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tests++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
    tests++; if (stopped !== 1'b0) begin fails++; $display("FAIL reset_stopped got %b want 0", stopped); end
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop_cnt got %h want 0", drop_cnt); end
  endtask

  task automatic test_in_order();
    logic [WIDTH-1:0] w;
    tick(0, '0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      w = 36'h1_0000_0000 + 36'(i);
      tick(1, w, 0, 1, 0);
      tests++; if (out_valid !== 1'b1 || out_data !== w)
        begin fails++; $display("FAIL in_order_word%0d got v=%b %h want v=1 %h", i, out_valid, out_data, w); end
    end
    tick(0, '0, 0, 1, 0);
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL in_order_empty got %b want 1", empty); end
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL in_order_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_overflow();
    tick(0, '0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      tick(1, 36'h2_0000_0000 + 36'(i), 0, 0, 0);
      if (i == 15) begin
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full_at16 got %b want 1", full); end
      end
    end
    tests++; if (drop_cnt !== 16'd4) begin fails++; $display("FAIL ovf_drop_cnt got %0d want 4", drop_cnt); end
    tests++; if (level !== 5'd16) begin fails++; $display("FAIL ovf_level got %0d want 16", level); end
    for (int i = 0; i < 16; i++) begin
      tests++; if (out_data !== 36'h2_0000_0000 + 36'(i))
        begin fails++; $display("FAIL ovf_drain%0d got %h want %h", i, out_data, 36'h2_0000_0000 + 36'(i)); end
      tick(0, '0, 0, 1, 0);
    end
`ifdef NANORV32_TRACE_BUF_OVF_MARKER_EN
    tests++; if (out_valid !== 1'b1 || out_data !== 36'hF_0000_0004)
      begin fails++; $display("FAIL ovf_marker got v=%b %h want v=1 f00000004", out_valid, out_data); end
    tick(0, '0, 0, 1, 0);
`endif
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ovf_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    tick(0, '0, 0, 0, 1);
    for (int k = 0; k < 16; k++) tick(1, 36'h3_0000_0000 + 36'(k), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tests++; if (out_data !== 36'h3_0000_0000 + 36'(i))
        begin fails++; $display("FAIL b2b_head%0d got %h want %h", i, out_data, 36'h3_0000_0000 + 36'(i)); end
      tick(1, 36'h3_0000_0010 + 36'(i), 0, 1, 0);
      tests++; if (level !== 5'd16) begin fails++; $display("FAIL b2b_level%0d got %0d want 16", i, level); end
    end
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL b2b_drop got %0d want 0", drop_cnt); end
    for (int i = 10; i < 26; i++) begin
      tests++; if (out_data !== 36'h3_0000_0000 + 36'(i))
        begin fails++; $display("FAIL b2b_drain%0d got %h want %h", i, out_data, 36'h3_0000_0000 + 36'(i)); end
      tick(0, '0, 0, 1, 0);
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got %b want 1", empty); end
  endtask

  task automatic test_stop();
    logic [WIDTH-1:0] w;
    tick(0, '0, 0, 0, 1);
    w = {4'(($urandom) & 32'h7), 32'($urandom)};
    tick(1, w, 1, 0, 0);
    for (int i = 0; i < 8; i++) tick(1, 36'h4_0000_0000 + 36'(i), 0, 0, 0);
    tests++; if (stopped !== 1'b1) begin fails++; $display("FAIL stop_flag got %b want 1", stopped); end
    tests++; if (level !== 5'd1) begin fails++; $display("FAIL stop_level got %0d want 1", level); end
    tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL stop_drop got %0d want 0", drop_cnt); end
    tests++; if (out_data !== w) begin fails++; $display("FAIL stop_word got %h want %h", out_data, w); end
    tick(1, 36'h4_0000_00FF, 0, 1, 0);
    tests++; if (empty !== 1'b1 || stopped !== 1'b1)
      begin fails++; $display("FAIL stop_drain got empty=%b stopped=%b want 1 1", empty, stopped); end
  endtask

  task automatic test_reset_mid();
    int guard;
    tick(0, '0, 0, 0, 1);
    for (int k = 0; k < 19; k++) tick(1, 36'h5_0000_0000 + 36'(k), 0, 0, 0);
    guard = 0;
    while (mq.size() > 9 && guard < 40) begin tick(0, '0, 0, 1, 0); guard++; end
    tests++; if (level !== 5'd9 || drop_cnt !== 16'd3)
      begin fails++; $display("FAIL rmid_pre got level=%0d drop=%0d want 9 3", level, drop_cnt); end
    tick(0, '0, 0, 0, 1);
    tests++; if (level !== 5'd0 || empty !== 1'b1 || out_valid !== 1'b0 || drop_cnt !== 16'd0)
      begin fails++; $display("FAIL rmid_post got level=%0d empty=%b valid=%b drop=%0d want 0 1 0 0", level, empty, out_valid, drop_cnt); end
    tick(1, 36'h5_ABCD_0123, 0, 0, 0);
    tests++; if (out_valid !== 1'b1 || out_data !== 36'h5_ABCD_0123 || level !== 5'd1)
      begin fails++; $display("FAIL rmid_push got v=%b %h lvl=%0d want 1 5abcd0123 1", out_valid, out_data, level); end
  endtask

  task automatic test_saturate();
    tick(0, '0, 0, 0, 1);
    for (int k = 0; k < 16; k++) tick(1, 36'(k), 0, 0, 0);
    for (int k = 0; k < 70000; k++) tick(1, 36'(k), 0, 0, 0);
    tests++; if (drop_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_drop got %h want ffff", drop_cnt); end
    tests++; if (level !== 5'd16) begin fails++; $display("FAIL sat_level got %0d want 16", level); end
  endtask

  task automatic test_random();
    tick(0, '0, 0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 3) != 0, {4'($urandom), 32'($urandom)},
           $urandom_range(0, 1499) == 0, $urandom_range(0, 2) != 0, 0);
      tests++; if (out_valid !== (mq.size() != 0) || out_data !== m_head())
        begin fails++; $display("FAIL rnd_out c%0d got v=%b %h want v=%b %h", c, out_valid, out_data, mq.size() != 0, m_head()); end
      tests++; if (level !== 5'(mq.size()) || drop_cnt !== 16'(m_drop) || stopped !== m_stop)
        begin fails++; $display("FAIL rnd_state c%0d got lvl=%0d drop=%0d stop=%b want %0d %0d %b", c, level, drop_cnt, stopped, mq.size(), m_drop, m_stop); end
    end
  endtask

  initial begin
    reset = 1'b1; trace_valid = 1'b0; trace_data = '0; trap = 1'b0; out_ready = 1'b0;
    test_reset();
    test_in_order();
    test_overflow();
    test_back_to_back();
    test_stop();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
